// File: rtl/ysyx_22050854_ifu_pkg.sv
// Shared definitions for the instruction-fetch unit.
//   - FSM state encoding (3 bits)
//   - NOP substituted for faulted fetches (addi x0,x0,0)
//   - default address / instruction widths
package ysyx_22050854_ifu_pkg;

  localparam int          IFU_ADDR_W   = 32;
  localparam int          IFU_INST_W   = 32;
  localparam logic [31:0] IFU_NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } ifu_state_e;

endpackage

// File: rtl/ysyx_22050854_inst_hold.sv
// Holding register for the instruction presented to the core.
// Ports:
//   clk, rst        clock, async active-low reset
//   load            capture load_inst/load_err and raise inst_valid
//   load_inst/err   data to capture
//   clear           drop inst_valid (consume or flush); data is kept
//   inst, fetch_err, inst_valid  registered outputs
// load wins over clear so a consume and a new capture can share a cycle.
module ysyx_22050854_inst_hold
  import ysyx_22050854_ifu_pkg::*;
#(
  parameter int                INST_W   = IFU_INST_W,
  parameter logic [INST_W-1:0] RST_INST = IFU_NOP_INST[INST_W-1:0]
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [INST_W-1:0] load_inst,
  input  logic              load_err,
  input  logic              clear,
  output logic [INST_W-1:0] inst,
  output logic              fetch_err,
  output logic              inst_valid
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst       <= RST_INST;
      fetch_err  <= 1'b0;
      inst_valid <= 1'b0;
    end else if (load) begin
      inst       <= load_inst;
      fetch_err  <= load_err;
      inst_valid <= 1'b1;
    end else if (clear) begin
      inst_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ysyx_22050854_inst_fetch.sv
// Instruction-fetch front end: one req/gnt/rvalid transaction at a time on
// the imem bus, result held for the core under inst_valid/core_ready.
// Ports:
//   clk, rst                       clock, async active-low reset
//   pc, fetch_req, flush           core request / redirect
//   inst, inst_valid, fetch_err    held instruction to core
//   core_ready                     core consumes inst
//   busy                           transaction outstanding (state != IDLE)
//   imem_req/addr/gnt/rvalid/rdata/err  instruction memory bus
// Optional: define YSYX_22050854_MISALIGN_CHK_EN to turn a fetch with
// pc[1:0]!=0 into an immediate faulted NOP without touching the bus.
module ysyx_22050854_inst_fetch
  import ysyx_22050854_ifu_pkg::*;
#(
  parameter int                ADDR_W   = IFU_ADDR_W,
  parameter int                INST_W   = IFU_INST_W,
  parameter logic [INST_W-1:0] NOP_INST = IFU_NOP_INST[INST_W-1:0]
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_req,
  input  logic              flush,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  input  logic              core_ready,
  output logic              fetch_err,
  output logic              busy,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              imem_err
);

  ifu_state_e        state, state_n;
  logic              drop, drop_n;
  logic              req_n;
  logic [ADDR_W-1:0] addr_n;
  logic              launch, misaligned;
  logic              h_load, h_clear, h_err;
  logic [INST_W-1:0] h_inst;

`ifdef YSYX_22050854_MISALIGN_CHK_EN
  assign misaligned = (pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_n = state;
    drop_n  = drop;
    req_n   = imem_req;
    addr_n  = imem_addr;
    launch  = 1'b0;
    h_load  = 1'b0;
    h_clear = 1'b0;
    h_inst  = NOP_INST;
    h_err   = 1'b0;
    case (state)
      S_IDLE: launch = fetch_req && !flush;
      S_REQ: begin
        // request stays up until granted even if flushed; remember the flush
        drop_n = drop || flush;
        if (imem_gnt) begin
          req_n   = 1'b0;
          state_n = (drop || flush) ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_n = imem_rvalid ? S_IDLE : S_DROP;
        end else if (imem_rvalid) begin
          h_load  = 1'b1;
          h_inst  = imem_err ? NOP_INST : imem_rdata;
          h_err   = imem_err;
          state_n = S_HOLD;
        end
      end
      S_HOLD: begin
        if (flush) begin
          h_clear = 1'b1;
          state_n = S_IDLE;
        end else if (core_ready) begin
          h_clear = 1'b1;
          state_n = S_IDLE;
          launch  = fetch_req;  // back-to-back, no IDLE bubble
        end
      end
      S_DROP: begin
        if (imem_rvalid) begin
          drop_n  = 1'b0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (launch) begin
      if (misaligned) begin
        h_load  = 1'b1;
        h_inst  = NOP_INST;
        h_err   = 1'b1;
        state_n = S_HOLD;
      end else begin
        req_n   = 1'b1;
        addr_n  = pc;
        state_n = S_REQ;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      drop      <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      drop      <= drop_n;
      imem_req  <= req_n;
      imem_addr <= addr_n;
      busy      <= (state_n != S_IDLE);
    end
  end

  ysyx_22050854_inst_hold #(
    .INST_W   (INST_W),
    .RST_INST (NOP_INST)
  ) u_hold (
    .clk        (clk),
    .rst        (rst),
    .load       (h_load),
    .load_inst  (h_inst),
    .load_err   (h_err),
    .clear      (h_clear),
    .inst       (inst),
    .fetch_err  (fetch_err),
    .inst_valid (inst_valid)
  );

endmodule

// File: tb/tb_ysyx_22050854_inst_fetch.sv
module tb_ysyx_22050854_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        fetch_req, flush, core_ready;
  logic [31:0] inst;
  logic        inst_valid, fetch_err, busy;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid, imem_err;
  logic [31:0] imem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_22050854_inst_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .fetch_req  (fetch_req),
    .flush      (flush),
    .inst       (inst),
    .inst_valid (inst_valid),
    .core_ready (core_ready),
    .fetch_err  (fetch_err),
    .busy       (busy),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .imem_err   (imem_err)
  );

  // {inst, inst_valid, fetch_err, busy, imem_req, imem_addr}
  typedef logic [67:0] obs_t;

  typedef struct {
    string       name;
    logic        fr, fl, cr, gnt, rv, er;
    logic [31:0] pc, rd;
    obs_t        exp;
  } vec_t;

  vec_t tbl[$];

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] A0  = 32'h8000_0000;

  function automatic obs_t o(input logic [31:0] i, input logic v, e, b, r,
                             input logic [31:0] a);
    return {i, v, e, b, r, a};
  endfunction

  function automatic obs_t act();
    return {inst, inst_valid, fetch_err, busy, imem_req, imem_addr};
  endfunction

  task automatic add(input string nm, input logic fr, fl, cr, gnt, rv, er,
                     input logic [31:0] p, rd, input obs_t e);
    vec_t t;
    t.name = nm; t.fr = fr; t.fl = fl; t.cr = cr; t.gnt = gnt; t.rv = rv;
    t.er = er; t.pc = p; t.rd = rd; t.exp = e;
    tbl.push_back(t);
  endtask

  task automatic check(input string nm, input obs_t e);
    checks++;
    if (act() !== e) begin
      errors++;
      $display("FAIL %s got=%h want=%h (inst,v,err,busy,req,addr)", nm, act(), e);
    end
  endtask

  task automatic drive(input logic fr, fl, cr, gnt, rv, er,
                       input logic [31:0] p, rd);
    fetch_req = fr; flush = fl; core_ready = cr; imem_gnt = gnt;
    imem_rvalid = rv; imem_err = er; pc = p; imem_rdata = rd;
  endtask

  initial begin
    //   name         fr fl cr g  rv er pc            rdata          exp
    add("basic_req",  1, 0, 0, 0, 0, 0, A0,           32'h0, o(NOP, 0, 0, 1, 1, A0));
    add("basic_gnt",  0, 0, 0, 1, 0, 0, 32'h0,        32'h0, o(NOP, 0, 0, 1, 0, A0));
    add("basic_rv",   0, 0, 0, 0, 1, 0, 32'h0, 32'h00100073, o(32'h00100073, 1, 0, 1, 0, A0));
    for (int k = 0; k < 5; k++)
      add("backpress", 1, 0, 0, 0, 0, 0, 32'h80000008, 32'h0, o(32'h00100073, 1, 0, 1, 0, A0));
    add("consume",    0, 0, 1, 0, 0, 0, 32'h0,        32'h0, o(32'h00100073, 0, 0, 0, 0, A0));
    add("stall_req",  1, 0, 0, 0, 0, 0, 32'h80000010, 32'h0, o(32'h00100073, 0, 0, 1, 1, 32'h80000010));
    add("stall_1",    0, 0, 0, 0, 0, 0, 32'h0,        32'h0, o(32'h00100073, 0, 0, 1, 1, 32'h80000010));
    add("stall_flush",0, 1, 0, 0, 0, 0, 32'h0,        32'h0, o(32'h00100073, 0, 0, 1, 1, 32'h80000010));
    add("stall_3",    0, 0, 0, 0, 0, 0, 32'h0,        32'h0, o(32'h00100073, 0, 0, 1, 1, 32'h80000010));
    add("stall_gnt",  0, 0, 0, 1, 0, 0, 32'h0,        32'h0, o(32'h00100073, 0, 0, 1, 0, 32'h80000010));
    add("drop_rv",    0, 0, 0, 0, 1, 0, 32'h0, 32'hDEADBEEF, o(32'h00100073, 0, 0, 0, 0, 32'h80000010));
    add("idle_quiet", 0, 0, 0, 0, 0, 0, 32'h0,        32'h0, o(32'h00100073, 0, 0, 0, 0, 32'h80000010));
    add("idle_flush", 1, 1, 0, 0, 0, 0, 32'h80000030, 32'h0, o(32'h00100073, 0, 0, 0, 0, 32'h80000010));
    add("err_req",    1, 0, 0, 0, 0, 0, 32'h80000020, 32'h0, o(32'h00100073, 0, 0, 1, 1, 32'h80000020));
    add("err_gnt",    0, 0, 0, 1, 0, 0, 32'h0,        32'h0, o(32'h00100073, 0, 0, 1, 0, 32'h80000020));
    add("err_rv",     0, 0, 0, 0, 1, 1, 32'h0, 32'h12345678, o(NOP, 1, 1, 1, 0, 32'h80000020));
    add("b2b_req",    1, 0, 1, 0, 0, 0, 32'h80000004, 32'h0, o(NOP, 0, 1, 1, 1, 32'h80000004));
    add("b2b_gnt",    0, 0, 0, 1, 0, 0, 32'h0,        32'h0, o(NOP, 0, 1, 1, 0, 32'h80000004));
    add("b2b_rv",     0, 0, 0, 0, 1, 0, 32'h0, 32'h00000517, o(32'h517, 1, 0, 1, 0, 32'h80000004));
    add("hold_flush", 1, 1, 1, 0, 0, 0, 32'h80000040, 32'h0, o(32'h517, 0, 0, 0, 0, 32'h80000004));
    add("wf_req",     1, 0, 0, 0, 0, 0, 32'h80000050, 32'h0, o(32'h517, 0, 0, 1, 1, 32'h80000050));
    add("wf_gnt",     0, 0, 0, 1, 0, 0, 32'h0,        32'h0, o(32'h517, 0, 0, 1, 0, 32'h80000050));
    add("wf_flush_rv",0, 1, 0, 0, 1, 0, 32'h0, 32'h0000AAAA, o(32'h517, 0, 0, 0, 0, 32'h80000050));
    add("wd_req",     1, 0, 0, 0, 0, 0, 32'h80000060, 32'h0, o(32'h517, 0, 0, 1, 1, 32'h80000060));
    add("wd_gnt",     0, 0, 0, 1, 0, 0, 32'h0,        32'h0, o(32'h517, 0, 0, 1, 0, 32'h80000060));
    add("wd_flush",   0, 1, 0, 0, 0, 0, 32'h0,        32'h0, o(32'h517, 0, 0, 1, 0, 32'h80000060));
    add("drop_ignfr", 1, 0, 0, 0, 0, 0, 32'h80000070, 32'h0, o(32'h517, 0, 0, 1, 0, 32'h80000060));
    add("drop_done",  0, 0, 0, 0, 1, 0, 32'h0, 32'h11111111, o(32'h517, 0, 0, 0, 0, 32'h80000060));

    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 check("reset", o(NOP, 0, 0, 0, 0, 32'h0));
    @(negedge clk) rst = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].fr, tbl[i].fl, tbl[i].cr, tbl[i].gnt, tbl[i].rv, tbl[i].er,
            tbl[i].pc, tbl[i].rd);
      @(posedge clk);
      #1 check(tbl[i].name, tbl[i].exp);
    end

    // reset asserted mid-WAIT, away from any clock edge
    @(negedge clk) drive(1, 0, 0, 0, 0, 0, 32'h80000080, 32'h0);
    @(posedge clk); #1 check("rw_req", o(32'h517, 0, 0, 1, 1, 32'h80000080));
    @(negedge clk) drive(0, 0, 0, 1, 0, 0, 32'h0, 32'h0);
    @(posedge clk); #1 check("rw_gnt", o(32'h517, 0, 0, 1, 0, 32'h80000080));
    @(negedge clk) drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    #2 rst = 1'b0;
    #1 check("async_reset", o(NOP, 0, 0, 0, 0, 32'h0));
    @(negedge clk) rst = 1'b1;

    // misaligned pc after reset release
    @(negedge clk) drive(1, 0, 0, 0, 0, 0, 32'h80000002, 32'h0);
    @(posedge clk);
`ifdef YSYX_22050854_MISALIGN_CHK_EN
    #1 check("misalign", o(NOP, 1, 1, 1, 0, 32'h0));
`else
    #1 check("misalign_pass", o(NOP, 0, 0, 1, 1, 32'h80000002));
`endif
    @(negedge clk) drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    @(posedge clk);
`ifdef YSYX_22050854_MISALIGN_CHK_EN
    #1 check("misalign_hold", o(NOP, 1, 1, 1, 0, 32'h0));
`else
    #1 check("misalign_hold", o(NOP, 0, 0, 1, 1, 32'h80000002));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
